// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared encodings for the MIPS32 pipeline front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  typedef enum logic [0:0] {
    IF_FETCH = 1'b0,
    IF_HELD  = 1'b1
  } if_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/pipe_if_hold.sv
// ============================================================================
// Module      : pipe_if_hold
// Description : One-entry buffer for a fetch that returns while ID is stalled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_if_hold (
  input  logic        clk,
  input  logic        clrn,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc4,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc4,
  output logic        o_valid
);

  logic [31:0] r_inst;
  logic [31:0] r_pc4;
  logic        r_valid;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_inst  <= 32'h0;
      r_pc4   <= 32'h0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_inst  <= i_inst;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_inst  = r_inst;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/pipe_if_fetch.sv
// ============================================================================
// Module      : pipe_if_fetch
// Description : IF stage: PC, next-PC select, imem handshake, IF/ID register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_if_fetch
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        nostall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] dinst,
  output logic [31:0] dpc4,
  output logic        dvalid
);

  if_state_e   r_state;
  if_state_e   w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_dinst;
  logic [31:0] r_dpc4;
  logic        r_dvalid;
  logic        r_redir_pend;
  logic [31:0] r_redir_tgt;

  logic        w_fetching;
  logic        w_held;
  logic        w_if_fire;
  logic        w_id_take;
  logic        w_redir;
  logic [31:0] w_tgt_raw;
  logic [31:0] w_tgt;
  logic [31:0] w_pc4;
  logic        w_hold_load;
  logic        w_hold_clear;
  logic [31:0] w_hold_inst;
  logic [31:0] w_hold_pc4;
  logic        w_hold_valid;

  assign w_fetching   = (r_state == IF_FETCH);
  assign w_held       = (r_state == IF_HELD);
  assign w_if_fire    = w_fetching & imem_ack;
  assign w_id_take    = ~r_dvalid | nostall;
  assign w_redir      = r_dvalid & nostall & (pcsrc != PCSRC_SEQ);
  assign w_pc4        = r_pc + 32'd4;
  assign w_hold_load  = ~w_id_take & w_if_fire;
  assign w_hold_clear = w_id_take & w_held;

  always_comb begin
    w_tgt_raw = jpc;
    case (pcsrc)
      PCSRC_BR: w_tgt_raw = bpc;
      PCSRC_JR: w_tgt_raw = rpc;
      PCSRC_J:  w_tgt_raw = jpc;
      default:  w_tgt_raw = jpc;
    endcase
  end

  // Targets are word aligned regardless of what ID presents.
  assign w_tgt = w_tgt_raw & 32'hFFFF_FFFC;

  pipe_if_hold u_hold (
    .clk     (clk),
    .clrn    (clrn),
    .i_load  (w_hold_load),
    .i_clear (w_hold_clear),
    .i_inst  (imem_rdata),
    .i_pc4   (w_pc4),
    .o_inst  (w_hold_inst),
    .o_pc4   (w_hold_pc4),
    .o_valid (w_hold_valid)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= IF_FETCH;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_id_take && w_held)          w_state_nxt = IF_FETCH;
    else if (!w_id_take && w_if_fire) w_state_nxt = IF_HELD;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_dinst  <= 32'h0;
      r_dpc4   <= 32'h0;
      r_dvalid <= 1'b0;
    end else if (w_id_take) begin
      if (w_held) begin
        r_dinst  <= w_hold_inst;
        r_dpc4   <= w_hold_pc4;
        r_dvalid <= 1'b1;
      end else if (w_if_fire) begin
        r_dinst  <= imem_rdata;
        r_dpc4   <= w_pc4;
        r_dvalid <= 1'b1;
      end else begin
        r_dvalid <= 1'b0;
      end
    end
  end

  // A redirect seen while the delay slot is still in flight is parked until
  // the slot returns, so the slot is fetched from the old PC first.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_pc         <= RESET_PC;
      r_redir_pend <= 1'b0;
      r_redir_tgt  <= 32'h0;
    end else if (w_redir && (w_held || w_if_fire)) begin
      r_pc <= w_tgt;
    end else if (w_redir) begin
      r_redir_pend <= 1'b1;
      r_redir_tgt  <= w_tgt;
    end else if (w_if_fire && r_redir_pend) begin
      r_pc         <= r_redir_tgt;
      r_redir_pend <= 1'b0;
    end else if (w_if_fire) begin
      r_pc <= w_pc4;
    end
  end

  assign imem_req  = w_fetching;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign dinst     = r_dinst;
  assign dpc4      = r_dpc4;
  assign dvalid    = r_dvalid;

  a_no_redir_while_pend : assert property (
    @(posedge clk) disable iff (!clrn) !(w_redir && r_redir_pend));

  a_hold_matches_state : assert property (
    @(posedge clk) disable iff (!clrn) (w_held == w_hold_valid));

endmodule

`default_nettype wire

// File: tb/tb_pipe_if_fetch.sv
// ============================================================================
// Module      : tb_pipe_if_fetch
// Description : Randomized bench for pipe_if_fetch against a program-order model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pipe_if_fetch;

  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] c_KEY      = 32'h5A3C_9601;
  localparam int          c_DEPTH    = 8192;

  logic        clk;
  logic        clrn;
  logic [1:0]  pcsrc;
  logic [31:0] bpc, rpc, jpc;
  logic        nostall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc, dinst, dpc4;
  logic        dvalid;

  pipe_if_fetch #(.RESET_PC(c_RESET_PC)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .pcsrc      (pcsrc),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .nostall    (nostall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .dinst      (dinst),
    .dpc4       (dpc4),
    .dvalid     (dvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Program-order model: instruction k lives at exp_pc[k]; a redirect taken
  // by instruction k dictates the address of instruction k+2 (delay slot).
  logic [31:0] exp_pc [0:c_DEPTH-1];
  bit          ov_v   [0:c_DEPTH-1];
  logic [31:0] ov_t   [0:c_DEPTH-1];
  int          n_fetch, n_take, total_take;

  bit          prev_wait, prev_stall, prev_cap, prev_slot;
  logic [31:0] prev_addr, prev_dinst, prev_dpc4, prev_tgt;

  task automatic model_reset();
    n_fetch = 0;
    n_take  = 0;
    for (int i = 0; i < c_DEPTH; i++) ov_v[i] = 1'b0;
    prev_wait  = 1'b0;
    prev_stall = 1'b0;
    prev_cap   = 1'b0;
    prev_slot  = 1'b0;
  endtask

  function automatic logic [31:0] model_fetch_pc(input int j);
    if (j == 0)   return c_RESET_PC;
    if (ov_v[j])  return ov_t[j];
    return exp_pc[j-1] + 32'd4;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'h0000_000F);
    return t;
  endfunction

  // One cycle, entered and left at a falling edge.
  task automatic cycle(input int ack_pct, input int stall_pct, input int redir_pct);
    bit          take, fire, redir;
    logic [31:0] t;
    nostall    = ($urandom_range(0, 99) >= stall_pct);
    imem_ack   = imem_req && ($urandom_range(0, 99) < ack_pct);
    imem_rdata = imem_ack ? (imem_addr ^ c_KEY) : $urandom;
    pcsrc      = ($urandom_range(0, 99) < redir_pct) ? 2'($urandom_range(1, 3)) : 2'b00;
    bpc        = rand_target();
    rpc        = rand_target();
    jpc        = rand_target();
    #1;
    take  = dvalid && nostall;
    fire  = imem_req && imem_ack;
    redir = 1'b0;
    t     = 32'h0;
    if (take) begin
      if (n_take >= n_fetch) begin
        chk("id_spurious", {31'b0, dvalid}, 32'h0);
      end else begin
        chk("id_inst", dinst, exp_pc[n_take] ^ c_KEY);
        chk("id_pc4",  dpc4,  exp_pc[n_take] + 32'd4);
        if (pcsrc != 2'b00) begin
          redir = 1'b1;
          case (pcsrc)
            2'b01:   t = bpc;
            2'b10:   t = rpc;
            default: t = jpc;
          endcase
          t = {t[31:2], 2'b00};
          ov_v[n_take+2] = 1'b1;
          ov_t[n_take+2] = t;
        end
      end
      n_take++;
      total_take++;
    end
    if (fire) begin
      exp_pc[n_fetch] = model_fetch_pc(n_fetch);
      chk("fetch_addr", imem_addr, exp_pc[n_fetch]);
      n_fetch++;
    end
    prev_wait  = imem_req && !imem_ack;
    prev_addr  = imem_addr;
    prev_stall = dvalid && !nostall;
    prev_dinst = dinst;
    prev_dpc4  = dpc4;
    prev_cap   = dvalid && !nostall && fire;
    prev_slot  = redir && fire;
    prev_tgt   = t;
    @(negedge clk);
    chk("pc_is_addr", pc, imem_addr);
    if (prev_wait)  chk("addr_stable", imem_addr, prev_addr);
    if (prev_stall) begin
      chk("dinst_hold", dinst, prev_dinst);
      chk("dpc4_hold",  dpc4,  prev_dpc4);
    end
    if (prev_cap)   chk("held_noreq", {31'b0, imem_req}, 32'h0);
    if (prev_slot) begin
      chk("redir_addr", imem_addr, prev_tgt);
      chk("redir_req",  {31'b0, imem_req}, 32'h1);
    end
  endtask

  task automatic run(input int n, input int ack_pct, input int stall_pct, input int redir_pct);
    for (int i = 0; i < n; i++) cycle(ack_pct, stall_pct, redir_pct);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_dvalid"}, {31'b0, dvalid}, 32'h0);
    chk({tag, "_dinst"},  dinst, 32'h0);
    chk({tag, "_dpc4"},   dpc4,  32'h0);
    chk({tag, "_pc"},     pc,    c_RESET_PC);
    chk({tag, "_addr"},   imem_addr, c_RESET_PC);
  endtask

  // Release at a falling edge; sequential fetch with ack every cycle.
  task automatic release_and_check_latency();
    model_reset();
    clrn = 1'b1;
    cycle(100, 0, 0);
    chk("lat1_dvalid", {31'b0, dvalid}, 32'h1);
    chk("lat1_dinst",  dinst, c_RESET_PC ^ c_KEY);
    chk("lat1_dpc4",   dpc4,  c_RESET_PC + 32'd4);
    chk("lat1_addr",   imem_addr, c_RESET_PC + 32'd4);
    cycle(100, 0, 0);
    chk("lat2_dpc4",   dpc4,  c_RESET_PC + 32'd8);
    chk("lat2_addr",   imem_addr, c_RESET_PC + 32'd8);
  endtask

  initial begin
    total_take = 0;
    clrn       = 1'b0;
    pcsrc      = 2'b00;
    bpc        = 32'h0;
    rpc        = 32'h0;
    jpc        = 32'h0;
    nostall    = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    chk("rst_req_ignored_ack", {31'b0, dvalid}, 32'h0);
    imem_ack = 1'b0;
    release_and_check_latency();

    run(20,  100,  0,  0);
    run(300, 100,  0, 15);
    run(400,  30,  0, 15);
    run(600,  60, 40, 15);
    run(400, 100, 50, 20);
    run(400,  20, 60, 20);

    // Reset asserted in the middle of a cycle with a fetch outstanding.
    imem_ack = 1'b0;
    nostall  = 1'b1;
    #2 clrn  = 1'b0;
    #1 check_reset_values("midrst");
    imem_ack   = 1'b1;
    imem_rdata = $urandom;
    @(negedge clk);
    check_reset_values("lateack");
    imem_ack = 1'b0;
    release_and_check_latency();

    run(500, 70, 30, 20);
    run(300, 100, 0, 25);

    chk("progress", {31'b0, (total_take > 200)}, 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
